// File: rtl/accum_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_datapath_pkg
// Description : Shared opcode constants and FSM state encoding for the
//               accumulator datapath and anything that drives it.
//               No ports; imported with  import accum_datapath_pkg::*;
// Revision    : 1.0  initial release
// ============================================================================
package accum_datapath_pkg;

    localparam logic [2:0] c_op_clr   = 3'b000;
    localparam logic [2:0] c_op_add   = 3'b001;
    localparam logic [2:0] c_op_sub   = 3'b010;
    localparam logic [2:0] c_op_disp  = 3'b011;
    localparam logic [2:0] c_op_load  = 3'b100;
    localparam logic [2:0] c_op_ldacc = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Opcodes 110 and 111 are reserved and flagged as errors.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= c_op_ldacc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/accum_datapath_alu.sv
`default_nettype none
// ============================================================================
// Module      : accum_alu
// Description : Combinational signed add/subtract with overflow detection
//               and optional clamping to the signed range.
// Ports       : acc      - accumulator operand (minuend / augend)
//               operand  - second operand
//               sub_sel  - 1 = acc - operand, 0 = acc + operand
//               result   - WIDTH-bit result (wrapped or clamped)
//               ovf      - result left the signed WIDTH-bit range
// Revision    : 1.0  initial release
// ============================================================================
module accum_alu #(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  logic             sub_sel,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH:0] w_acc_ext;
    logic [WIDTH:0] w_opd_ext;
    logic [WIDTH:0] w_sum;

    // One guard bit of sign extension is enough to hold any sum/difference
    // of two WIDTH-bit signed values exactly.
    assign w_acc_ext = {acc[WIDTH-1], acc};
    assign w_opd_ext = {operand[WIDTH-1], operand};
    assign w_sum     = sub_sel ? (w_acc_ext - w_opd_ext) : (w_acc_ext + w_opd_ext);

    // Guard bit disagreeing with the WIDTH-bit sign means the exact result
    // does not fit; the guard bit carries the true sign.
    assign ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

    generate
        if (SATURATE != 0) begin : g_sat
            always_comb begin
                result = w_sum[WIDTH-1:0];
                if (ovf) begin
                    result = w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
        end else begin : g_wrap
            assign result = w_sum[WIDTH-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/accum_datapath.sv
`default_nettype none
// ============================================================================
// Module      : accum_datapath
// Description : Two-state instruction-driven accumulator. An instruction is
//               captured in IDLE and committed on the following edge (EXEC),
//               giving at most one instruction every two cycles.
//               Registers: X (operand), Y (accumulator), Z (display).
// Ports       : clk, rst_n (async, active-low)
//               in_valid / in_ready   - instruction handshake
//               op[2:0], data_in      - opcode and LOAD/LDACC operand
//               data_out              - display register Z
//               out_valid             - pulse, Z updated by DISP
//               ovf / ovf_sticky      - overflow pulse / sticky flag
//               sign                  - MSB of data_out
//               err                   - pulse, illegal opcode accepted
// Revision    : 1.0  initial release
// ============================================================================
module accum_datapath
    import accum_datapath_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             ovf,
    output logic             ovf_sticky,
    output logic             sign,
    output logic             err
);

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic             r_out_valid;
    logic             r_ovf;
    logic             r_ovf_sticky;
    logic             r_err;
    logic             w_accept;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_ovf;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated by rst_n so the source sees not-ready while reset
                // is held, even though the state register already reads IDLE.
                in_ready = rst_n;
                if (in_valid) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Instruction capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= c_op_clr;
            r_data <= '0;
        end else if (w_accept) begin
            r_op   <= op;
            r_data <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // Arithmetic
    // ------------------------------------------------------------------
    accum_alu #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_alu (
        .acc     (r_y),
        .operand (r_x),
        .sub_sel (r_op == c_op_sub),
        .result  (w_alu_result),
        .ovf     (w_alu_ovf)
    );

    // ------------------------------------------------------------------
    // Commit: only in EXEC, so a reset during EXEC drops the instruction.
    // Pulse outputs default low every cycle, making them one cycle wide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_z          <= '0;
            r_out_valid  <= 1'b0;
            r_ovf        <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            if (r_state == ST_EXEC) begin
                if (!op_is_legal(r_op)) begin
                    r_err <= 1'b1;
                end else begin
                    case (r_op)
                        c_op_clr: begin
                            r_x          <= '0;
                            r_y          <= '0;
                            r_z          <= '0;
                            r_ovf_sticky <= 1'b0;
                        end
                        c_op_add, c_op_sub: begin
                            r_y <= w_alu_result;
                            if (w_alu_ovf) begin
                                r_ovf        <= 1'b1;
                                r_ovf_sticky <= 1'b1;
                            end
                        end
                        c_op_disp: begin
                            r_z         <= r_y;
                            r_out_valid <= 1'b1;
                        end
                        c_op_load: begin
                            r_x <= r_data;
                        end
                        c_op_ldacc: begin
                            r_y <= r_data;
                        end
                        default: begin
                            r_err <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign data_out   = r_z;
    assign out_valid  = r_out_valid;
    assign ovf        = r_ovf;
    assign ovf_sticky = r_ovf_sticky;
    assign sign       = r_z[WIDTH-1];
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_accum_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_datapath
// Description : Scoreboard bench for accum_datapath. Two instances (wrap and
//               saturate) share one stimulus stream; a reference model pushes
//               the expected post-commit outputs, and a monitor pops them in
//               the cycle after each EXEC.
// Revision    : 1.0  initial release
// ============================================================================
module tb_accum_datapath;
    import accum_datapath_pkg::*;

    localparam int W    = 8;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    typedef struct {
        int z;
        bit ov;
        bit ovf;
        bit sticky;
        bit err;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [2:0]   op;
    logic [W-1:0] data_in;

    logic         rdy0, rdy1;
    logic [W-1:0] dout0, dout1;
    logic         ov0, ov1, ovf0, ovf1, stk0, stk1, sgn0, sgn1, err0, err1;

    int checks   = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state, index 0 = wrap, 1 = saturate
    int mx[2];
    int my[2];
    int mz[2];
    bit mstk[2];

    int ovf_cnt0 = 0, ovf_cnt1 = 0, ov_cnt0 = 0, err_cnt0 = 0;

    accum_datapath #(.WIDTH(W), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .op(op), .data_in(data_in), .data_out(dout0), .out_valid(ov0),
        .ovf(ovf0), .ovf_sticky(stk0), .sign(sgn0), .err(err0)
    );

    accum_datapath #(.WIDTH(W), .SATURATE(1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .op(op), .data_in(data_in), .data_out(dout1), .out_valid(ov1),
        .ovf(ovf1), .ovf_sticky(stk1), .sign(sgn1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain integer arithmetic on the opcode rules
    // ------------------------------------------------------------------
    function automatic int wrap_w(input int r);
        int m;
        m = r & ((1 << W) - 1);
        if (m > MAXV) m = m - (1 << W);
        return m;
    endfunction

    function automatic exp_t model_step(input int s, input logic [2:0] o, input int d);
        exp_t e;
        int   r;
        e.ov = 0; e.ovf = 0; e.err = 0;
        case (o)
            3'd0: begin mx[s] = 0; my[s] = 0; mz[s] = 0; mstk[s] = 0; end
            3'd1, 3'd2: begin
                r = (o == 3'd1) ? my[s] + mx[s] : my[s] - mx[s];
                if (r > MAXV || r < MINV) begin
                    e.ovf   = 1;
                    mstk[s] = 1;
                    if (s == 1) my[s] = (r > MAXV) ? MAXV : MINV;
                    else        my[s] = wrap_w(r);
                end else begin
                    my[s] = r;
                end
            end
            3'd3: begin mz[s] = my[s]; e.ov = 1; end
            3'd4: mx[s] = d;
            3'd5: my[s] = d;
            default: e.err = 1;
        endcase
        e.z      = mz[s];
        e.sticky = mstk[s];
        return e;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            mx[s] = 0; my[s] = 0; mz[s] = 0; mstk[s] = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    bit   pending = 0;
    exp_t last0 = '{0, 0, 0, 0, 0};
    exp_t last1 = '{0, 0, 0, 0, 0};

    task automatic cmp_commit(input string p, input exp_t e, input logic [W-1:0] d,
                              input logic v, input logic f, input logic st,
                              input logic sg, input logic er);
        chk({p, "_data_out"},   int'($signed(d)), e.z);
        chk({p, "_out_valid"},  int'(v),  int'(e.ov));
        chk({p, "_ovf"},        int'(f),  int'(e.ovf));
        chk({p, "_ovf_sticky"}, int'(st), int'(e.sticky));
        chk({p, "_sign"},       int'(sg), int'(e.z < 0));
        chk({p, "_err"},        int'(er), int'(e.err));
    endtask

    task automatic cmp_hold(input string p, input exp_t e, input logic [W-1:0] d,
                            input logic v, input logic f, input logic st, input logic er);
        chk({p, "_hold_data_out"}, int'($signed(d)), e.z);
        chk({p, "_hold_sticky"},   int'(st), int'(e.sticky));
        chk({p, "_hold_pulses"},   int'({v, f, er}), 0);
    endtask

    always @(negedge clk) begin
        if (ovf0) ovf_cnt0++;
        if (ovf1) ovf_cnt1++;
        if (ov0)  ov_cnt0++;
        if (err0) err_cnt0++;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            last0 = '{0, 0, 0, 0, 0};
            last1 = '{0, 0, 0, 0, 0};
        end
        if (pending && rst_n) begin
            if (q0.size() == 0 || q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow commit seen with no expected entry @%0t", $time);
            end else begin
                last0 = q0.pop_front();
                last1 = q1.pop_front();
                cmp_commit("wrap", last0, dout0, ov0, ovf0, stk0, sgn0, err0);
                cmp_commit("sat",  last1, dout1, ov1, ovf1, stk1, sgn1, err1);
            end
        end else begin
            cmp_hold("wrap", last0, dout0, ov0, ovf0, stk0, err0);
            cmp_hold("sat",  last1, dout1, ov1, ovf1, stk1, err1);
        end
        pending = rst_n && !rdy0;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic push(input logic [2:0] o, input logic [W-1:0] d);
        int dv;
        dv = int'($signed(d));
        q0.push_back(model_step(0, o, dv));
        q1.push_back(model_step(1, o, dv));
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] d);
        int budget;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        data_in  = d;
        #1;
        budget = 0;
        while (!rdy0 && budget < 20) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (!rdy0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout in_ready=%0d required=1", rdy0);
        end else begin
            push(o, d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
        #1;
    endtask

    int base_a, base_b, accepts;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = 3'd0;
        data_in  = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", int'(rdy0), 0);
        chk("rst_data_out", int'(dout0), 0);
        chk("rst_pulses",   int'({ov0, ovf0, err0, ov1, ovf1, err1}), 0);
        chk("rst_sticky",   int'({stk0, stk1}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", int'(rdy0), 1);

        // Wrap vs saturate on a positive overflow
        base_a = ovf_cnt0; base_b = ovf_cnt1;
        issue(c_op_clr, 8'd0);
        issue(c_op_load, 8'd100);
        issue(c_op_add, 8'd0);
        issue(c_op_add, 8'd0);
        issue(c_op_disp, 8'd0);
        drain();
        chk("seq1_wrap_dout",   int'($signed(dout0)), -56);
        chk("seq1_sat_dout",    int'($signed(dout1)), 127);
        chk("seq1_wrap_sign",   int'(sgn0), 1);
        chk("seq1_sticky",      int'({stk0, stk1}), 3);
        chk("seq1_wrap_ovfcnt", ovf_cnt0 - base_a, 1);
        chk("seq1_sat_ovfcnt",  ovf_cnt1 - base_b, 1);

        // Subtraction and negative overflow
        base_a = ovf_cnt0;
        issue(c_op_clr, 8'd0);
        issue(c_op_load, 8'd5);
        issue(c_op_sub, 8'd0);
        issue(c_op_disp, 8'd0);
        drain();
        chk("seq2_dout",   int'($signed(dout0)), -5);
        chk("seq2_ovfcnt", ovf_cnt0 - base_a, 0);
        chk("seq2_sticky", int'(stk0), 0);
        issue(c_op_ldacc, 8'h80);
        issue(c_op_sub, 8'd0);
        issue(c_op_disp, 8'd0);
        drain();
        chk("seq3_wrap_dout", int'($signed(dout0)), 123);
        chk("seq3_sat_dout",  int'($signed(dout1)), -128);
        chk("seq3_ovfcnt",    ovf_cnt0 - base_a, 1);

        // Illegal opcodes
        base_a = err_cnt0;
        issue(3'b110, 8'd33);
        issue(3'b111, 8'd44);
        issue(c_op_disp, 8'd0);
        drain();
        chk("illegal_errcnt",  err_cnt0 - base_a, 2);
        chk("illegal_dout",    int'($signed(dout0)), 123);

        // in_valid held high: one accept every two cycles
        issue(c_op_clr, 8'd0);
        issue(c_op_load, 8'd7);
        issue(c_op_ldacc, 8'd10);
        @(negedge clk);
        #1;
        while (!rdy0) begin @(negedge clk); #1; end
        in_valid = 1'b1;
        op       = c_op_add;
        accepts  = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            chk("held_in_ready", int'(rdy0), (i % 2 == 0) ? 1 : 0);
            if (rdy0) begin
                push(c_op_add, data_in);
                accepts++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("held_accepts", accepts, 3);
        issue(c_op_disp, 8'd0);
        drain();
        chk("held_dout", int'($signed(dout0)), 31);

        // Randomised instruction stream
        for (int n = 0; n < 150; n++) begin
            issue(3'($urandom_range(0, 7)), W'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        // Reset during EXEC of a DISP
        issue(c_op_ldacc, 8'd55);
        issue(c_op_disp, 8'd0);
        issue(c_op_ldacc, 8'd66);
        drain();
        chk("pre_reset_dout", int'($signed(dout0)), 55);
        base_a = ov_cnt0;
        issue(c_op_disp, 8'd0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("exec_rst_dout",     int'(dout0), 0);
        chk("exec_rst_in_ready", int'(rdy0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("exec_rst_release_ready", int'(rdy0), 1);
        repeat (3) @(negedge clk);
        #1;
        chk("exec_rst_no_out_valid", ov_cnt0 - base_a, 0);
        chk("exec_rst_dout_after",   int'(dout0), 0);
        issue(c_op_ldacc, 8'd9);
        issue(c_op_disp, 8'd0);
        drain();
        chk("post_reset_dout", int'($signed(dout0)), 9);

        chk("scoreboard_empty", q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/accum_datapath.md
ACCUM_DATAPATH -- requirements
Module: accum_datapath

Interface
REQ-001 Parameter WIDTH, default 8, sets the data, operand, accumulator and display register width (signed two's complement, WIDTH >= 4).
REQ-002 Parameter SATURATE, default 0: 0 = wrap-around arithmetic, 1 = clamp to signed min/max on overflow.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  instruction/data offered this cycle.
REQ-006 in_ready  output  1  block can accept an instruction this cycle.
REQ-007 op  input  3  opcode: 000 CLR, 001 ADD, 010 SUB, 011 DISP, 100 LOAD, 101 LDACC, 110/111 illegal.
REQ-008 data_in  input  WIDTH  operand for LOAD/LDACC.
REQ-009 data_out  output  WIDTH  display register Z.
REQ-010 out_valid  output  1  one-cycle pulse: Z updated by DISP.
REQ-011 ovf  output  1  one-cycle pulse: ADD/SUB result overflowed signed range.
REQ-012 ovf_sticky  output  1  set by any overflow, cleared only by CLR or reset.
REQ-013 sign  output  1  MSB of data_out.
REQ-014 err  output  1  one-cycle pulse: illegal opcode accepted.

Function
REQ-015 FSM states IDLE and EXEC only; IDLE drives in_ready=1, EXEC drives in_ready=0.
REQ-016 Handshake: transfer occurs on a rising edge with in_valid=1 and in_ready=1; op and data_in are captured into internal latches and FSM moves IDLE->EXEC.
REQ-017 EXEC always returns to IDLE next edge, committing the captured instruction; max throughput one instruction per 2 cycles.
REQ-018 Commit latency: registers and pulses reflect an instruction accepted at edge k from edge k+1 onward; pulses last exactly one cycle.
REQ-019 CLR: X, Y, Z, ovf_sticky <= 0.
REQ-020 ADD: Y <= Y + X; SUB: Y <= Y - X; both signed, computed at WIDTH+1 bits.
REQ-021 Overflow when the WIDTH+1-bit result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1]; ovf pulses and ovf_sticky sets.
REQ-022 On overflow, SATURATE=0 keeps low WIDTH bits; SATURATE=1 writes max positive or min negative according to true result sign.
REQ-023 DISP: Z <= Y, out_valid pulses; LOAD: X <= data_in; LDACC: Y <= data_in.
REQ-024 Illegal opcode: no register changes, err pulses, FSM still passes through EXEC.
REQ-025 in_valid while in_ready=0 is ignored; the source must hold it until accepted.

Reset
REQ-026 rst_n=0 immediately forces FSM to IDLE, X=Y=Z=0, ovf_sticky=0, out_valid=ovf=err=0, in_ready=0 while asserted.
REQ-027 Reset asserted during EXEC discards the pending instruction; no partial commit.
REQ-028 in_ready rises in the first cycle after rst_n deasserts.

Structure
REQ-029 Opcode constants and the IDLE/EXEC state encoding reside in a shared package used by this block and its bench.
REQ-030 Add/sub, overflow detection and saturation reside in one combinational sub-module accum_alu, parameterised by WIDTH and SATURATE.

Verification (WIDTH=8)
REQ-031 LOAD 100, ADD, ADD, DISP with SATURATE=0 -> data_out=-56 (0xC8), ovf pulse on second ADD, ovf_sticky=1, sign=1.
REQ-032 Same sequence with SATURATE=1 -> data_out=127, ovf pulse once, ovf_sticky=1.
REQ-033 CLR, LOAD 5, SUB, DISP -> data_out=-5 (0xFB), no ovf; LDACC -128, SUB (X=5) -> ovf=1, Y=123 (SAT=0) or -128 (SAT=1).
REQ-034 in_valid held high with ADD for 6 cycles -> exactly 3 accepts, in_ready toggles 1/0, Y advances by X three times.
REQ-035 op=110 accepted -> err pulse one cycle, X/Y/Z/ovf_sticky unchanged.
REQ-036 rst_n pulled low in EXEC of DISP -> out_valid never pulses, data_out=0, in_ready=1 first cycle after release.
